// File: rtl/uart_tx_arbiter.sv
// Two-requester byte arbiter in front of a single UART transmitter.
// Each requester owns a small FIFO; an optional line lock keeps one requester's text line contiguous.

module uart_tx_fifo #(
  parameter int AW = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr,
  input  logic [7:0] data,
  input  logic       pop,
  output logic [7:0] head,
  output logic       empty,
  output logic       full,
  output logic       ovf
);
  logic [7:0]    mem [1<<AW];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   cnt, cnt_nxt;
  logic          acc;

  // A pop in the same cycle frees a slot, so a write into a full FIFO still lands.
  assign acc   = wr && (!full || pop);
  assign empty = (cnt == '0);
  assign head  = mem[rptr];

  always_comb begin
    cnt_nxt = cnt;
    if (acc && !pop)      cnt_nxt = cnt + 1'b1;
    else if (pop && !acc) cnt_nxt = cnt - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
      full <= 1'b0;
      ovf  <= 1'b0;
    end else begin
      if (acc) wptr <= wptr + 1'b1;
      if (pop) rptr <= rptr + 1'b1;
      cnt  <= cnt_nxt;
      full <= cnt_nxt[AW];
      if (wr && !acc) ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (acc) mem[wptr] <= data;
  end
endmodule

module uart_tx_arbiter #(
  parameter int          AW           = 2,
  parameter bit          LINE_LOCK    = 1'b1,
  parameter logic [15:0] LOCK_TIMEOUT = 16'd50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] req0_data,
  input  logic       req0_wr,
  output logic       req0_full,
  output logic       req0_ovf,
  input  logic [7:0] req1_data,
  input  logic       req1_wr,
  output logic       req1_full,
  output logic       req1_ovf,
  output logic [7:0] tx_din,
  output logic       tx_valid,
  input  logic       tx_idle,
  output logic       grant,
  output logic       busy
);
  localparam int NUM_REQ = 2;

  typedef enum logic [1:0] {S_IDLE, S_WAIT_BUSY, S_WAIT_IDLE} state_t;

  state_t                   state;
  logic [NUM_REQ-1:0]       wr, pop, empty, full, ovf;
  logic [NUM_REQ-1:0][7:0]  wdata, head;
  logic                     lock, owner, cand, cand_ok, timeout, lock_act, issue;
  logic [15:0]              lock_timer;

  assign wr        = {req1_wr, req0_wr};
  assign wdata     = {req1_data, req0_data};
  assign req0_full = full[0];
  assign req1_full = full[1];
  assign req0_ovf  = ovf[0];
  assign req1_ovf  = ovf[1];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_req
    uart_tx_fifo #(.AW(AW)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .wr    (wr[i]),
      .data  (wdata[i]),
      .pop   (pop[i]),
      .head  (head[i]),
      .empty (empty[i]),
      .full  (full[i]),
      .ovf   (ovf[i])
    );
  end

  // An expiring lock is already void in this evaluation, so the other side can win now.
  assign timeout  = lock && (lock_timer == LOCK_TIMEOUT);
  assign lock_act = lock && !timeout;

  always_comb begin
    cand    = 1'b0;
    cand_ok = 1'b0;
    if (lock_act) begin
      cand    = owner;
      cand_ok = !empty[owner];
    end else if (!empty[0] && !empty[1]) begin
      cand    = ~grant;
      cand_ok = 1'b1;
    end else if (!empty[0]) begin
      cand    = 1'b0;
      cand_ok = 1'b1;
    end else if (!empty[1]) begin
      cand    = 1'b1;
      cand_ok = 1'b1;
    end
  end

  assign issue = (state == S_IDLE) && tx_idle && cand_ok;
  assign pop   = issue ? (cand ? 2'b10 : 2'b01) : 2'b00;

  // The transmitter's idle flag lags the start pulse, so S_WAIT_BUSY ignores a stale idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      tx_valid   <= 1'b0;
      tx_din     <= '0;
      grant      <= 1'b1;
      busy       <= 1'b0;
      lock       <= 1'b0;
      owner      <= 1'b0;
      lock_timer <= '0;
    end else begin
      tx_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (timeout) begin
            lock       <= 1'b0;
            lock_timer <= '0;
          end else if (lock_act && empty[owner]) begin
            lock_timer <= lock_timer + 1'b1;
          end
          if (issue) begin
            tx_din     <= head[cand];
            tx_valid   <= 1'b1;
            grant      <= cand;
            lock_timer <= '0;
            if (LINE_LOCK) begin
              lock  <= (head[cand] != 8'h0A);
              owner <= cand;
            end
            state <= S_WAIT_BUSY;
            busy  <= 1'b1;
          end
        end
        S_WAIT_BUSY: begin
          if (!tx_idle) state <= S_WAIT_IDLE;
        end
        S_WAIT_IDLE: begin
          if (tx_idle) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: a locking instance (timeout 100) and a pure round-robin one,
// each driven by a small transmitter model whose idle flag lags the start pulse.

module tb_uart_tx_arbiter;
  localparam int FRAME = 20;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] req0_data = '0, req1_data = '0;
  logic       req0_wr = 1'b0, req1_wr = 1'b0;
  logic       req0_full, req0_ovf, req1_full, req1_ovf;
  logic [7:0] tx_din;
  logic       tx_valid, grant, busy;
  logic       tx_idle = 1'b1;

  logic [7:0] r_d0 = '0, r_d1 = '0;
  logic       r_wr0 = 1'b0, r_wr1 = 1'b0;
  logic       r_full0, r_ovf0, r_full1, r_ovf1;
  logic [7:0] r_din;
  logic       r_valid, r_grant, r_busy;
  logic       r_idle = 1'b1;

  int vecs = 0, errs = 0, wide = 0;
  logic [7:0] q0[$], qr[$];
  logic       tlag = 1'b0, r_tlag = 1'b0, vprev = 1'b0, r_vprev = 1'b0;
  int         tcnt = 0, r_tcnt = 0;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.AW(2), .LINE_LOCK(1'b1), .LOCK_TIMEOUT(16'd100)) dut (
    .clk(clk), .reset(reset),
    .req0_data(req0_data), .req0_wr(req0_wr), .req0_full(req0_full), .req0_ovf(req0_ovf),
    .req1_data(req1_data), .req1_wr(req1_wr), .req1_full(req1_full), .req1_ovf(req1_ovf),
    .tx_din(tx_din), .tx_valid(tx_valid), .tx_idle(tx_idle), .grant(grant), .busy(busy)
  );

  uart_tx_arbiter #(.AW(2), .LINE_LOCK(1'b0), .LOCK_TIMEOUT(16'd100)) dut_rr (
    .clk(clk), .reset(reset),
    .req0_data(r_d0), .req0_wr(r_wr0), .req0_full(r_full0), .req0_ovf(r_ovf0),
    .req1_data(r_d1), .req1_wr(r_wr1), .req1_full(r_full1), .req1_ovf(r_ovf1),
    .tx_din(r_din), .tx_valid(r_valid), .tx_idle(r_idle), .grant(r_grant), .busy(r_busy)
  );

  // Transmitter models and issue monitors, all on the falling edge.
  always @(negedge clk) begin
    if (tlag) begin tlag <= 1'b0; tx_idle <= 1'b0; tcnt <= FRAME; end
    else if (!tx_idle) begin if (tcnt == 0) tx_idle <= 1'b1; else tcnt <= tcnt - 1; end
    if (tx_valid) begin tlag <= 1'b1; q0.push_back(tx_din); end
    if (r_tlag) begin r_tlag <= 1'b0; r_idle <= 1'b0; r_tcnt <= FRAME; end
    else if (!r_idle) begin if (r_tcnt == 0) r_idle <= 1'b1; else r_tcnt <= r_tcnt - 1; end
    if (r_valid) begin r_tlag <= 1'b1; qr.push_back(r_din); end
    if ((tx_valid && vprev) || (r_valid && r_vprev)) wide <= wide + 1;
    vprev   <= tx_valid;
    r_vprev <= r_valid;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_free(input string tag);
    int n = 0;
    while (busy && n < 500) begin tick; n++; end
    chk(tag, busy, 1'b0);
  endtask

  task automatic wait_q(input string tag, input int want, input bit rr);
    int n = 0;
    while (((rr ? qr.size() : q0.size()) < want) && n < 1000) begin tick; n++; end
    chk(tag, rr ? qr.size() : q0.size(), want);
  endtask

  task automatic pulse_reset;
    reset = 1'b1;
    tick;
    reset = 1'b0;
  endtask

  initial begin
    int n, m;
    // Reset state
    tick; tick; tick;
    reset = 1'b0;
    chk("rst_full0", req0_full, 1'b0);
    chk("rst_ovf0", req0_ovf, 1'b0);
    chk("rst_valid", tx_valid, 1'b0);
    chk("rst_din", tx_din, 8'h00);
    chk("rst_grant", grant, 1'b1);
    chk("rst_busy", busy, 1'b0);

    // Single byte: two-edge write-to-issue latency
    req0_data = 8'h55; req0_wr = 1'b1;
    tick;
    req0_wr = 1'b0;
    chk("single_e0_valid", tx_valid, 1'b0);
    tick;
    chk("single_valid", tx_valid, 1'b1);
    chk("single_din", tx_din, 8'h55);
    chk("single_grant", grant, 1'b0);
    chk("single_busy", busy, 1'b1);
    tick;
    chk("single_pulse_end", tx_valid, 1'b0);
    chk("single_busy_hold", busy, 1'b1);
    wait_free("single_done");
    chk("single_idle_at_done", tx_idle, 1'b1);

    // Round-robin on the unlocked instance
    r_d0 = 8'h41; r_d1 = 8'h61; r_wr0 = 1'b1; r_wr1 = 1'b1;
    tick;
    r_d0 = 8'h42; r_d1 = 8'h62;
    tick;
    r_wr0 = 1'b0; r_wr1 = 1'b0;
    wait_q("rr_count", 4, 1'b1);
    if (qr.size() >= 4) begin
      chk("rr_0", qr[0], 8'h41);
      chk("rr_1", qr[1], 8'h61);
      chk("rr_2", qr[2], 8'h42);
      chk("rr_3", qr[3], 8'h62);
    end

    // Line lock keeps requester 0's line together
    pulse_reset;
    q0.delete();
    req0_data = 8'h48; req1_data = 8'h78; req0_wr = 1'b1; req1_wr = 1'b1;
    tick;
    req1_wr = 1'b0; req0_data = 8'h49;
    tick;
    req0_data = 8'h0A;
    tick;
    req0_wr = 1'b0;
    wait_q("lock_count", 4, 1'b0);
    if (q0.size() >= 4) begin
      chk("lock_0", q0[0], 8'h48);
      chk("lock_1", q0[1], 8'h49);
      chk("lock_2", q0[2], 8'h0A);
      chk("lock_3", q0[3], 8'h78);
    end
    wait_free("lock_done");

    // Lock timeout: 100 empty-owner cycles, then the other requester wins
    pulse_reset;
    q0.delete();
    req0_data = 8'h48; req0_wr = 1'b1;
    tick;
    req0_wr = 1'b0; req1_data = 8'h78; req1_wr = 1'b1;
    tick;
    req1_wr = 1'b0;
    n = 0;
    while (!busy && n < 10) begin tick; n++; end
    wait_free("to_frame_done");
    n = 0;
    while (!tx_valid && n < 300) begin tick; n++; end
    chk("to_wait_cycles", n[15:0], 16'd101);
    chk("to_din", tx_din, 8'h78);
    chk("to_grant", grant, 1'b1);
    wait_free("to_done");

    // Overflow, then write+pop on a full FIFO
    pulse_reset;
    q0.delete();
    req0_wr = 1'b1;
    for (int i = 0; i < 5; i++) begin
      req0_data = 8'h11 + ((i == 0) ? 8'h00 : 8'h0F + i[7:0]);
      tick;
    end
    chk("ovf_full4", req0_full, 1'b1);
    chk("ovf_before", req0_ovf, 1'b0);
    req0_data = 8'h25;
    tick;
    req0_wr = 1'b0;
    chk("ovf_full5", req0_full, 1'b1);
    chk("ovf_set", req0_ovf, 1'b1);
    wait_free("ovf_frame_done");
    req0_data = 8'h26; req0_wr = 1'b1;
    tick;
    req0_wr = 1'b0;
    chk("wp_valid", tx_valid, 1'b1);
    chk("wp_din", tx_din, 8'h21);
    chk("wp_full", req0_full, 1'b1);
    chk("wp_ovf_sticky", req0_ovf, 1'b1);
    wait_q("ovf_count", 6, 1'b0);
    if (q0.size() >= 6) begin
      chk("ovf_q2", q0[2], 8'h22);
      chk("ovf_q3", q0[3], 8'h23);
      chk("ovf_q4", q0[4], 8'h24);
      chk("ovf_q5", q0[5], 8'h26);
    end

    // Reset while the transmitter is mid-frame with data queued
    req0_wr = 1'b1; req0_data = 8'h31;
    tick;
    req0_data = 8'h32;
    tick;
    req0_wr = 1'b0;
    n = 0;
    while (tx_idle && n < 20) begin tick; n++; end
    chk("mf_tx_busy", tx_idle, 1'b0);
    pulse_reset;
    chk("mf_full", req0_full, 1'b0);
    chk("mf_ovf", req0_ovf, 1'b0);
    chk("mf_busy", busy, 1'b0);
    chk("mf_grant", grant, 1'b1);
    m = q0.size();
    n = 0;
    while (!tx_idle && n < 100) begin tick; n++; end
    repeat (5) tick;
    chk("mf_no_issue", q0.size(), m);
    req0_data = 8'h5A; req0_wr = 1'b1;
    tick;
    req0_wr = 1'b0;
    tick;
    chk("mf_post_valid", tx_valid, 1'b1);
    chk("mf_post_din", tx_din, 8'h5A);
    wait_free("mf_done");

    chk("pulse_width", wide, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
